ofm_bram_arbiter: RTL and testbench
===================================

OFM_BRAM_ARBITER -- requirements
Module: ofm_bram_arbiter

Interface
REQ-001 SHALL have parameter BRAM_DATA_WIDTH, default 32, meaning the BRAM word width.
REQ-002 SHALL have parameter BRAM_ADDRESS_WIDTH, default 16, meaning the BRAM address width (64*64*64/4 words).
REQ-003 SHALL have parameter BURST, default 4, meaning the maximum consecutive grants to one requester while the other waits.
REQ-004 SHALL have parameter RD_LAT, default 1, meaning the BRAM read latency in cycles (range 1-3).
REQ-005 SHALL have one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port clk, input, 1 bit, the clock (rising edge).
REQ-007 SHALL have port rst, input, 1 bit, the asynchronous active-high reset.
REQ-008 SHALL have wr_req, wr_addr, wr_data as inputs of 1/BRAM_ADDRESS_WIDTH/BRAM_DATA_WIDTH bits, meaning the write request from the output feature packer.
REQ-009 SHALL have output wr_gnt, 1 bit, meaning the write is accepted this cycle.
REQ-010 SHALL have rd_req and rd_addr as inputs of 1/BRAM_ADDRESS_WIDTH bits, meaning the readback request from the host/DMA.
REQ-011 SHALL have output rd_gnt, 1 bit, meaning the read is issued this cycle.
REQ-012 SHALL have outputs rd_data, BRAM_DATA_WIDTH bits, and rd_vld, 1 bit, meaning the returned read word.
REQ-013 SHALL have bram_en, bram_we, bram_addr and bram_wdata as outputs, and bram_rdata as an input, meaning the single BRAM port.
REQ-014 SHALL have output busy, 1 bit, which is high when the state is not IDLE or a read is in flight.

Function
REQ-015 SHALL use FSM states IDLE, WR and RD, held in a register with a burst counter burst_cnt of width clog2(BURST)+1.
REQ-016 SHALL compute grants combinationally from the state and the current requests, with at most one of wr_gnt and rd_gnt high in any cycle.
REQ-017 In IDLE, SHALL grant the write if wr_req, else grant the read if rd_req, else grant nothing; a write therefore wins a simultaneous request from IDLE.
REQ-018 In WR or RD, SHALL keep granting the current owner while it requests and either the other side is idle or burst_cnt < BURST.
REQ-019 SHALL switch the grant to the other side in the same cycle when the current owner drops its request while the other side requests.
REQ-020 SHALL switch the grant to the other side when burst_cnt == BURST and the other side requests.
REQ-021 SHALL move the state to the owner of the cycle's grant, or to IDLE if there is no grant.
REQ-022 SHALL set burst_cnt to 1 on a grant that changes owner, increment it on a repeated grant (saturating at BURST), and clear it to 0 in IDLE.
REQ-023 On a write grant, SHALL drive bram_en=1, bram_we=1, bram_addr=wr_addr and bram_wdata=wr_data in the same cycle.
REQ-024 On a read grant, SHALL drive bram_en=1, bram_we=0 and bram_addr=rd_addr in the same cycle.
REQ-025 With no grant, SHALL drive bram_en=0 and bram_we=0, and hold bram_addr and bram_wdata at 0.
REQ-026 SHALL carry read grants through an RD_LAT-deep valid shift register.
REQ-027 SHALL assert rd_vld exactly RD_LAT cycles after the rd_gnt cycle, with rd_data=bram_rdata sampled on that cycle.
REQ-028 Back-to-back reads SHALL produce back-to-back rd_vld pulses with no bubbles.
REQ-029 A write granted in the cycle after a read SHALL NOT corrupt the in-flight rd_data, because the BRAM port is read-first.
REQ-030 SHALL hold rd_data when rd_vld=0.
REQ-031 SHALL never let a requester starve: the worst-case wait while the other side requests continuously is BURST cycles.

Reset
REQ-032 While rst=1, SHALL immediately (asynchronously) force state=IDLE, burst_cnt=0, the valid shift register to 0, rd_vld=0, rd_data=0 and busy=0.
REQ-033 While rst=1, SHALL force wr_gnt=0, rd_gnt=0, bram_en=0 and bram_we=0 regardless of the requests.
REQ-034 Reads in flight at reset assertion SHALL be discarded and produce no rd_vld after release.
REQ-035 On the first rising edge after rst deasserts, SHALL arbitrate as from IDLE.

Verification
REQ-036 Reset mid-read: rst pulsed one cycle after rd_gnt with RD_LAT=2 -> rd_vld never asserts, and busy=0 during reset.
REQ-037 Write only: wr_req held for 8 cycles with addresses 0..7 and data 0x03020100 + 0x04040404*i -> 8 consecutive wr_gnt and bram_we, with bram_addr matching.
REQ-038 Simultaneous requests from IDLE: wr_req=rd_req=1, BURST=4 -> the grant pattern is W,W,W,W,R,R,R,R,W... and no requester waits more than 4 cycles.
REQ-039 Read latency: rd_req for addresses 5,6,7 with RD_LAT=1 and BRAM preloaded with 0x55/0x66/0x77 -> rd_vld high for 3 cycles starting 1 cycle after the first rd_gnt, with rd_data=0x55,0x66,0x77.
REQ-040 Hand-off: the owner drops its request while the other is pending -> the other side is granted in the same cycle and burst_cnt=1.
REQ-041 Idle: no requests for 10 cycles -> bram_en=0, state=IDLE and busy=0 throughout.

Source files
------------

// File: rtl/ofm_bram_arbiter.sv
// ofm_bram_arbiter: shares one read-first BRAM port between the output
// feature packer (writes) and the host/DMA readback path (reads).
// Arbitration is write-first from idle and is bounded by BURST consecutive
// grants while the other side waits. Read data returns RD_LAT cycles after
// the read grant.
module ofm_bram_arbiter #(
  parameter int BRAM_DATA_WIDTH    = 32,
  parameter int BRAM_ADDRESS_WIDTH = 16,
  parameter int BURST              = 4,
  parameter int RD_LAT             = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_req,
  input  logic [BRAM_ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [BRAM_DATA_WIDTH-1:0]    wr_data,
  output logic                          wr_gnt,
  input  logic                          rd_req,
  input  logic [BRAM_ADDRESS_WIDTH-1:0] rd_addr,
  output logic                          rd_gnt,
  output logic [BRAM_DATA_WIDTH-1:0]    rd_data,
  output logic                          rd_vld,
  output logic                          bram_en,
  output logic                          bram_we,
  output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr,
  output logic [BRAM_DATA_WIDTH-1:0]    bram_wdata,
  input  logic [BRAM_DATA_WIDTH-1:0]    bram_rdata,
  output logic                          busy
);

  localparam int CW = $clog2(BURST) + 1;
  localparam logic [CW-1:0] BURST_C = CW'(BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  state_t                     state;
  logic [CW-1:0]              burst_cnt;
  logic [RD_LAT-1:0]          vld_sr;
  logic [BRAM_DATA_WIDTH-1:0] rd_hold;
  logic [CW-1:0]              burst_inc;

  // Saturating increment used when the same owner is granted again.
  assign burst_inc = (burst_cnt == BURST_C) ? BURST_C : (burst_cnt + CW'(1));

  // Grant decision: owner keeps the port until it drops or exhausts its burst
  // while the other side is waiting; reset masks every grant.
  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (rst) begin
      wr_gnt = 1'b0;
      rd_gnt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_req) begin
            wr_gnt = 1'b1;
          end else if (rd_req) begin
            rd_gnt = 1'b1;
          end else begin
            wr_gnt = 1'b0;
          end
        end
        WR: begin
          if (wr_req && (!rd_req || (burst_cnt < BURST_C))) begin
            wr_gnt = 1'b1;
          end else if (rd_req) begin
            rd_gnt = 1'b1;
          end else begin
            wr_gnt = 1'b0;
          end
        end
        RD: begin
          if (rd_req && (!wr_req || (burst_cnt < BURST_C))) begin
            rd_gnt = 1'b1;
          end else if (wr_req) begin
            wr_gnt = 1'b1;
          end else begin
            rd_gnt = 1'b0;
          end
        end
        default: begin
          wr_gnt = 1'b0;
          rd_gnt = 1'b0;
        end
      endcase
    end
  end

  // BRAM port drive follows the grant in the same cycle; idle port is zeroed.
  always_comb begin
    bram_en    = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = '0;
    bram_wdata = '0;
    if (wr_gnt) begin
      bram_en    = 1'b1;
      bram_we    = 1'b1;
      bram_addr  = wr_addr;
      bram_wdata = wr_data;
    end else if (rd_gnt) begin
      bram_en    = 1'b1;
      bram_addr  = rd_addr;
    end else begin
      bram_en    = 1'b0;
    end
  end

  // Ownership state and burst counter track who received this cycle's grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else if (wr_gnt) begin
      state     <= WR;
      burst_cnt <= (state == WR) ? burst_inc : CW'(1);
    end else if (rd_gnt) begin
      state     <= RD;
      burst_cnt <= (state == RD) ? burst_inc : CW'(1);
    end else begin
      state     <= IDLE;
      burst_cnt <= '0;
    end
  end

  // Read-valid pipeline matching the BRAM read latency; reset drops in-flight reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= rd_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
    end
  end

  // Keep the last returned word so rd_data stays stable between valid pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_hold <= '0;
    end else if (rd_vld) begin
      rd_hold <= bram_rdata;
    end else begin
      rd_hold <= rd_hold;
    end
  end

  // The valid word is taken straight from the BRAM in its return cycle; the
  // read-first port keeps it intact even if a write is issued that cycle.
  assign rd_vld  = vld_sr[RD_LAT-1];
  assign rd_data = rd_vld ? bram_rdata : rd_hold;
  assign busy    = (state != IDLE) || (|vld_sr);

endmodule

// File: tb/tb_ofm_bram_arbiter.sv
// Directed bench for ofm_bram_arbiter: a read-first BRAM model behind a
// RD_LAT=1 instance, plus a RD_LAT=2 instance for the reset-mid-read case.
module tb_ofm_bram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_req = 1'b0;
  logic [15:0] wr_addr = 16'd0;
  logic [31:0] wr_data = 32'd0;
  logic        rd_req = 1'b0;
  logic [15:0] rd_addr = 16'd0;

  logic        wr_gnt, rd_gnt, rd_vld, bram_en, bram_we, busy;
  logic [31:0] rd_data, bram_wdata;
  logic [15:0] bram_addr;
  logic [31:0] bram_rdata = 32'd0;

  logic        wr_gnt2, rd_gnt2, rd_vld2, bram_en2, bram_we2, busy2;
  logic [31:0] rd_data2, bram_wdata2;
  logic [15:0] bram_addr2;
  logic [31:0] bram_rdata2 = 32'hDEAD_BEEF;

  logic [31:0] mem [0:255];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ofm_bram_arbiter #(.BRAM_DATA_WIDTH(32), .BRAM_ADDRESS_WIDTH(16), .BURST(4), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_data(rd_data), .rd_vld(rd_vld),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata), .busy(busy)
  );

  ofm_bram_arbiter #(.BRAM_DATA_WIDTH(32), .BRAM_ADDRESS_WIDTH(16), .BURST(4), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt2),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt2),
    .rd_data(rd_data2), .rd_vld(rd_vld2),
    .bram_en(bram_en2), .bram_we(bram_we2), .bram_addr(bram_addr2),
    .bram_wdata(bram_wdata2), .bram_rdata(bram_rdata2), .busy(busy2)
  );

  // Read-first single-port BRAM model, one cycle read latency.
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr[7:0]] <= bram_wdata;
      bram_rdata <= mem[bram_addr[7:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then settle before checks.
  task automatic cyc(input logic w, input logic [15:0] wa, input logic [31:0] wd,
                     input logic r, input logic [15:0] ra);
    @(negedge clk);
    wr_req = w; wr_addr = wa; wr_data = wd;
    rd_req = r; rd_addr = ra;
    #1;
  endtask

  initial begin
    // Reset forces grants and port enables low even with both requests up.
    @(negedge clk);
    wr_req = 1'b1; rd_req = 1'b1;
    #1;
    check("rst_wr_gnt", 32'(wr_gnt), 32'd0);
    check("rst_rd_gnt", 32'(rd_gnt), 32'd0);
    check("rst_bram_en", 32'(bram_en), 32'd0);
    check("rst_bram_we", 32'(bram_we), 32'd0);
    check("rst_rd_vld", 32'(rd_vld), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    wr_req = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Idle for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 16'd0, 32'd0, 1'b0, 16'd0);
      check("idle_bram_en", 32'(bram_en), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_state", 32'(int'(dut.state)), 32'd0);
    end

    // Write-only stream of 8 words.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 16'(i), 32'h0302_0100 + 32'h0404_0404 * 32'(i), 1'b0, 16'd0);
      check("wr_gnt", 32'(wr_gnt), 32'd1);
      check("wr_bram_we", 32'(bram_we), 32'd1);
      check("wr_bram_addr", 32'(bram_addr), 32'(i));
      check("wr_bram_wdata", bram_wdata, 32'h0302_0100 + 32'h0404_0404 * 32'(i));
    end

    // Preload addresses 5,6,7 with 0x55/0x66/0x77.
    cyc(1'b1, 16'd5, 32'h55, 1'b0, 16'd0);
    cyc(1'b1, 16'd6, 32'h66, 1'b0, 16'd0);
    cyc(1'b1, 16'd7, 32'h77, 1'b0, 16'd0);
    cyc(1'b0, 16'd0, 32'd0, 1'b0, 16'd0);
    check("pre_idle_wdata", bram_wdata, 32'd0);
    check("pre_idle_addr", 32'(bram_addr), 32'd0);

    // Back-to-back reads, followed by a write straight after the last read.
    cyc(1'b0, 16'd0, 32'd0, 1'b1, 16'd5);
    check("rd0_gnt", 32'(rd_gnt), 32'd1);
    check("rd0_we", 32'(bram_we), 32'd0);
    check("rd0_addr", 32'(bram_addr), 32'd5);
    check("rd0_vld", 32'(rd_vld), 32'd0);
    cyc(1'b0, 16'd0, 32'd0, 1'b1, 16'd6);
    check("rd1_gnt", 32'(rd_gnt), 32'd1);
    check("rd1_vld", 32'(rd_vld), 32'd1);
    check("rd1_data", rd_data, 32'h55);
    cyc(1'b0, 16'd0, 32'd0, 1'b1, 16'd7);
    check("rd2_gnt", 32'(rd_gnt), 32'd1);
    check("rd2_vld", 32'(rd_vld), 32'd1);
    check("rd2_data", rd_data, 32'h66);
    cyc(1'b1, 16'd7, 32'h99, 1'b0, 16'd0);
    check("rdw_wr_gnt", 32'(wr_gnt), 32'd1);
    check("rdw_vld", 32'(rd_vld), 32'd1);
    check("rdw_data", rd_data, 32'h77);
    cyc(1'b0, 16'd0, 32'd0, 1'b0, 16'd0);
    check("rd_hold_vld", 32'(rd_vld), 32'd0);
    check("rd_hold_data", rd_data, 32'h77);
    cyc(1'b0, 16'd0, 32'd0, 1'b0, 16'd0);
    check("rd_hold_data2", rd_data, 32'h77);

    // Simultaneous requests from idle: W x4, R x4, W x2.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 16'd20, 32'hA0 + 32'(i), 1'b1, 16'd30);
      check("both_wr_gnt", 32'(wr_gnt), ((i < 4) || (i >= 8)) ? 32'd1 : 32'd0);
      check("both_rd_gnt", 32'(rd_gnt), ((i >= 4) && (i < 8)) ? 32'd1 : 32'd0);
    end
    cyc(1'b0, 16'd0, 32'd0, 1'b0, 16'd0);
    cyc(1'b0, 16'd0, 32'd0, 1'b0, 16'd0);
    cyc(1'b0, 16'd0, 32'd0, 1'b0, 16'd0);

    // Hand-off: writer drops while reader waits.
    cyc(1'b1, 16'd40, 32'h1, 1'b0, 16'd0);
    cyc(1'b1, 16'd41, 32'h2, 1'b0, 16'd0);
    cyc(1'b1, 16'd42, 32'h3, 1'b1, 16'd50);
    check("ho_wr_keep", 32'(wr_gnt), 32'd1);
    cyc(1'b0, 16'd0, 32'd0, 1'b1, 16'd50);
    check("ho_rd_gnt", 32'(rd_gnt), 32'd1);
    check("ho_wr_gnt", 32'(wr_gnt), 32'd0);
    cyc(1'b0, 16'd0, 32'd0, 1'b0, 16'd0);
    check("ho_burst_cnt", 32'(dut.burst_cnt), 32'd1);
    check("ho_state_rd", 32'(int'(dut.state)), 32'd2);
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'd0, 32'd0, 1'b0, 16'd0);

    // Reset one cycle after a read grant on the RD_LAT=2 instance.
    cyc(1'b0, 16'd0, 32'd0, 1'b1, 16'd5);
    check("rr_gnt2", 32'(rd_gnt2), 32'd1);
    @(negedge clk);
    rd_req = 1'b0;
    rst = 1'b1;
    #1;
    check("rr_busy2", 32'(busy2), 32'd0);
    check("rr_vld2", 32'(rd_vld2), 32'd0);
    check("rr_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rr_vld2_rel", 32'(rd_vld2), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 16'd0, 32'd0, 1'b0, 16'd0);
      check("rr_vld2_after", 32'(rd_vld2), 32'd0);
      check("rr_vld_after", 32'(rd_vld), 32'd0);
    end

    // After release arbitration restarts from idle: write wins.
    cyc(1'b1, 16'd60, 32'h6, 1'b1, 16'd61);
    check("post_rst_wr_gnt", 32'(wr_gnt), 32'd1);
    check("post_rst_rd_gnt", 32'(rd_gnt), 32'd0);
    cyc(1'b0, 16'd0, 32'd0, 1'b0, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
